// File: rtl/poly_term_evaluator.sv
// poly_term_evaluator
// Sequential evaluator for sum-of-monomials polynomials in in1/in2/in3.
// Terms arrive as (coef, e1, e2, e3, last) over a valid/ready handshake.
// Each term is built by repeated multiplication, one factor per cycle,
// then added into the accumulator. All arithmetic wraps modulo 2^OUT_W.
module poly_term_evaluator #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 24,
  parameter int EXP_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IN_W-1:0]  in1,
  input  logic [IN_W-1:0]  in2,
  input  logic [IN_W-1:0]  in3,
  input  logic             term_valid,
  output logic             term_ready,
  input  logic [OUT_W-1:0] term_coef,
  input  logic [EXP_W-1:0] term_e1,
  input  logic [EXP_W-1:0] term_e2,
  input  logic [EXP_W-1:0] term_e3,
  input  logic             term_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [OUT_W-1:0] result,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_MUL,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  // Latched variable values, zero-extended to the arithmetic width.
  logic [OUT_W-1:0] x1;
  logic [OUT_W-1:0] x2;
  logic [OUT_W-1:0] x3;

  // Running sum and the product of the term currently being built.
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] prod;

  // Remaining multiplications per variable for the current term.
  logic [EXP_W-1:0] c1;
  logic [EXP_W-1:0] c2;
  logic [EXP_W-1:0] c3;
  logic             last_q;

  // Registered result, only non-zero while in DONE.
  logic [OUT_W-1:0] result_q;

  // Derived control.
  logic             start_fire;
  logic             term_fire;
  logic             res_fire;
  logic             need_c1;
  logic             need_c2;
  logic             need_c3;
  logic             term_finish;

  // Shared datapath.
  logic [OUT_W-1:0] mul_op;
  logic [OUT_W-1:0] prod_mul;
  logic [OUT_W-1:0] acc_sum;

  assign start_fire  = (state == S_IDLE) && start;
  assign term_fire   = (state == S_ACCEPT) && term_valid;
  assign res_fire    = (state == S_DONE) && res_ready;

  assign need_c1     = (c1 != '0);
  assign need_c2     = (c2 != '0);
  assign need_c3     = (c3 != '0);
  assign term_finish = (state == S_MUL) && !need_c1 && !need_c2 && !need_c3;

  // Single multiplier: the operand follows the c1 > c2 > c3 priority order.
  always_comb begin
    mul_op = x3;
    if (need_c1) begin
      mul_op = x1;
    end else if (need_c2) begin
      mul_op = x2;
    end
  end

  assign prod_mul = prod * mul_op;
  assign acc_sum  = acc + prod;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        if (term_valid) begin
          state_nxt = S_MUL;
        end
      end
      S_MUL: begin
        if (term_finish) begin
          state_nxt = last_q ? S_DONE : S_ACCEPT;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Variable capture on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      x1 <= '0;
      x2 <= '0;
      x3 <= '0;
    end else if (start_fire) begin
      x1 <= OUT_W'(in1);
      x2 <= OUT_W'(in2);
      x3 <= OUT_W'(in3);
    end
  end

  // Term load and exponent countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod   <= '0;
      c1     <= '0;
      c2     <= '0;
      c3     <= '0;
      last_q <= 1'b0;
    end else if (term_fire) begin
      prod   <= term_coef;
      c1     <= term_e1;
      c2     <= term_e2;
      c3     <= term_e3;
      last_q <= term_last;
    end else if (state == S_MUL) begin
      if (need_c1) begin
        prod <= prod_mul;
        c1   <= c1 - EXP_W'(1);
      end else if (need_c2) begin
        prod <= prod_mul;
        c2   <= c2 - EXP_W'(1);
      end else if (need_c3) begin
        prod <= prod_mul;
        c3   <= c3 - EXP_W'(1);
      end
    end
  end

  // Accumulator: cleared on start, summed once per completed term.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (start_fire) begin
      acc <= '0;
    end else if (term_finish) begin
      acc <= acc_sum;
    end
  end

  // Result register: loaded with the final sum on entry to DONE, held until
  // the handshake, zero otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
    end else if (term_finish && last_q) begin
      result_q <= acc_sum;
    end else if (state != S_DONE || res_fire) begin
      result_q <= '0;
    end
  end

  assign term_ready = (state == S_ACCEPT);
  assign res_valid  = (state == S_DONE);
  assign busy       = (state != S_IDLE);
  assign result     = result_q;

endmodule

// File: tb/tb_poly_term_evaluator.sv
// tb_poly_term_evaluator
// Directed vectors with hand-computed expected results for poly_term_evaluator.
module tb_poly_term_evaluator;

  localparam int IN_W  = 8;
  localparam int OUT_W = 24;
  localparam int EXP_W = 3;

  logic             clk;
  logic             rst;
  logic             start;
  logic [IN_W-1:0]  in1;
  logic [IN_W-1:0]  in2;
  logic [IN_W-1:0]  in3;
  logic             term_valid;
  logic             term_ready;
  logic [OUT_W-1:0] term_coef;
  logic [EXP_W-1:0] term_e1;
  logic [EXP_W-1:0] term_e2;
  logic [EXP_W-1:0] term_e3;
  logic             term_last;
  logic             res_valid;
  logic             res_ready;
  logic [OUT_W-1:0] result;
  logic             busy;

  int unsigned n_checks;
  int unsigned n_fail;

  poly_term_evaluator #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .EXP_W (EXP_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in1        (in1),
    .in2        (in2),
    .in3        (in3),
    .term_valid (term_valid),
    .term_ready (term_ready),
    .term_coef  (term_coef),
    .term_e1    (term_e1),
    .term_e2    (term_e2),
    .term_e3    (term_e3),
    .term_last  (term_last),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .result     (result),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    in1   = a;
    in2   = b;
    in3   = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one term and wait (bounded) for it to be accepted.
  task automatic send_term(input string tag, input logic [23:0] coef,
                           input int e1, input int e2, input int e3, input logic last);
    int unsigned waited;
    waited = 0;
    while (!term_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!term_ready) check_eq({tag, "_ready_timeout"}, 32'(term_ready), 32'd1);
    term_coef  = coef;
    term_e1    = 3'(e1);
    term_e2    = 3'(e2);
    term_e3    = 3'(e3);
    term_last  = last;
    term_valid = 1'b1;
    tick();
    term_valid = 1'b0;
    term_last  = 1'b0;
  endtask

  // Wait for res_valid (bounded), check latency and value; no handshake.
  task automatic wait_result(input string tag, input logic [23:0] exp, input int lat);
    int unsigned waited;
    waited = 0;
    while (!res_valid && waited < 100) begin
      tick();
      waited++;
    end
    check_eq({tag, "_valid"}, 32'(res_valid), 32'd1);
    check_eq({tag, "_lat"}, waited, 32'(lat));
    check_eq({tag, "_result"}, 32'(result), 32'(exp));
  endtask

  task automatic take_result(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_idle_result"}, 32'(result), 32'd0);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    start      = 1'b0;
    in1        = '0;
    in2        = '0;
    in3        = '0;
    term_valid = 1'b0;
    term_coef  = '0;
    term_e1    = '0;
    term_e2    = '0;
    term_e3    = '0;
    term_last  = 1'b0;
    res_ready  = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_term_ready", 32'(term_ready), 32'd0);
    check_eq("rst_res_valid", 32'(res_valid), 32'd0);
    check_eq("rst_result", 32'(result), 32'd0);

    // in1=5, in3=7: 1*in1*in3 = 35; res_valid 4 cycles after acceptance
    do_start(8'd5, 8'd0, 8'd7);
    check_eq("t1_busy", 32'(busy), 32'd1);
    check_eq("t1_term_ready", 32'(term_ready), 32'd1);
    send_term("t1", 24'd1, 1, 0, 1, 1'b1);
    check_eq("t1_mul_ready", 32'(term_ready), 32'd0);
    check_eq("t1_mul_result", 32'(result), 32'd0);
    wait_result("t1", 24'd35, 3);
    take_result("t1");

    // in1^3 = 27
    do_start(8'd3, 8'd0, 8'd0);
    send_term("t2a", 24'd1, 3, 0, 0, 1'b1);
    wait_result("t2a", 24'd27, 4);
    take_result("t2a");

    // 255^3 = 16581375, no wrap
    do_start(8'd255, 8'd0, 8'd0);
    send_term("t2b", 24'd1, 3, 0, 0, 1'b1);
    wait_result("t2b", 24'd16581375, 4);
    take_result("t2b");

    // 8388608*3 = 25165824 mod 2^24 = 8388608
    do_start(8'd3, 8'd0, 8'd0);
    send_term("t3a", 24'd8388608, 1, 0, 0, 1'b1);
    wait_result("t3a", 24'd8388608, 2);
    take_result("t3a");

    // Constant term 0xFFFFFF added directly
    do_start(8'd3, 8'd0, 8'd0);
    send_term("t3b", 24'hFFFFFF, 0, 0, 0, 1'b1);
    wait_result("t3b", 24'hFFFFFF, 1);
    take_result("t3b");

    // 0xC00000*in1*in3 + 0x400000*in1 with in1=in3=1 wraps to 0; stall between terms
    do_start(8'd1, 8'd0, 8'd1);
    send_term("t4a", 24'hC00000, 1, 0, 1, 1'b0);
    for (int i = 0; i < 10 && !term_ready; i++) tick();
    for (int i = 0; i < 3; i++) begin
      check_eq("t4_stall_ready", 32'(term_ready), 32'd1);
      check_eq("t4_stall_valid", 32'(res_valid), 32'd0);
      tick();
    end
    send_term("t4b", 24'd4194304, 1, 0, 0, 1'b1);
    wait_result("t4", 24'd0, 2);
    take_result("t4");

    // Hold in DONE with start pulsed: 3*in1^2, in1=2 -> 12
    do_start(8'd2, 8'd0, 8'd0);
    send_term("t5", 24'd3, 2, 0, 0, 1'b1);
    wait_result("t5", 24'd12, 3);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      tick();
      check_eq("t5_hold_valid", 32'(res_valid), 32'd1);
      check_eq("t5_hold_result", 32'(result), 32'd12);
    end
    start     = 1'b1;
    res_ready = 1'b1;
    tick();
    start     = 1'b0;
    res_ready = 1'b0;
    check_eq("t5_idle_busy", 32'(busy), 32'd0);
    check_eq("t5_idle_valid", 32'(res_valid), 32'd0);
    tick();
    check_eq("t5_no_restart", 32'(busy), 32'd0);

    // Reset in the middle of a long multiply chain
    do_start(8'd3, 8'd3, 8'd3);
    send_term("t6", 24'd1, 7, 7, 7, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t6_rst_busy", 32'(busy), 32'd0);
    check_eq("t6_rst_result", 32'(result), 32'd0);
    check_eq("t6_rst_ready", 32'(term_ready), 32'd0);
    check_eq("t6_rst_valid", 32'(res_valid), 32'd0);

    // Fresh run after reset: in2^4 with in2=2 -> 16
    do_start(8'd0, 8'd2, 8'd0);
    send_term("t7", 24'd1, 0, 4, 0, 1'b1);
    wait_result("t7", 24'd16, 5);
    take_result("t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
